// File: rtl/feq.sv
// Tolerant single-precision equality compare. Sign, exponent and the top
// MANT_BITS mantissa bits must match; NaN never matches; +0 equals -0.
module feq #(
    parameter int unsigned MANT_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        Feq_en,
    output logic [31:0] eqdata_out
);

    // Mask of mantissa bits that take part in the compare (top nbits of 23).
    function automatic logic [22:0] mant_mask_f(input int unsigned nbits);
        logic [22:0] mask;
        mask = 23'd0;
        for (int i = 0; i < 23; i++) begin
            if ((i + int'(nbits)) >= 23) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

    // NaN uses the full mantissa so a low-bit payload is never masked away.
    function automatic logic is_nan_f(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_zero_f(input logic [31:0] x);
        return (x[30:0] == 31'd0);
    endfunction

    localparam logic [22:0] MANT_MASK = mant_mask_f(MANT_BITS);

    logic        w_equal;
    logic [31:0] w_result;
    logic [31:0] r_eqdata;

    // Equality decision in priority order: NaN, signed zeros, field match.
    always_comb begin
        w_equal = 1'b0;
        if (is_nan_f(read_data1) || is_nan_f(read_data2)) begin
            w_equal = 1'b0;
        end else if (is_zero_f(read_data1) && is_zero_f(read_data2)) begin
            w_equal = 1'b1;
        end else begin
            w_equal = (read_data1[31] == read_data2[31]) &&
                      (read_data1[30:23] == read_data2[30:23]) &&
                      (((read_data1[22:0] ^ read_data2[22:0]) & MANT_MASK) == 23'd0);
        end
    end

    // Result word with the enable gating folded in.
    always_comb begin
        w_result = {31'd0, (Feq_en & w_equal)};
    end

    // Output register, reloaded every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eqdata <= 32'd0;
        end else begin
            r_eqdata <= w_result;
        end
    end

    assign eqdata_out = r_eqdata;

endmodule

// File: tb/tb_feq.sv
// Scoreboard bench for feq: two instances (MANT_BITS 7 and 23) share inputs;
// a reference model pushes expectations, a monitor pops and compares.
module tb_feq;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic [31:0] out7;
    logic [31:0] out23;

    typedef struct {
        int          id;
        logic [31:0] exp7;
        logic [31:0] exp23;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    feq #(.MANT_BITS(7)) dut (
        .clk(clk), .rst(rst), .read_data1(a), .read_data2(b),
        .Feq_en(en), .eqdata_out(out7)
    );

    feq #(.MANT_BITS(23)) dut23 (
        .clk(clk), .rst(rst), .read_data1(a), .read_data2(b),
        .Feq_en(en), .eqdata_out(out23)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a value is NaN if its magnitude exceeds +inf's encoding;
    // otherwise compare the top (9 + m) bits of the words as integers.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic e, input logic r, input int m);
        logic eq;
        if (r || !e) return 32'd0;
        if ((x & 32'h7FFF_FFFF) > 32'h7F80_0000 || (y & 32'h7FFF_FFFF) > 32'h7F80_0000)
            eq = 1'b0;
        else if ((x << 1) == 32'd0 && (y << 1) == 32'd0)
            eq = 1'b1;
        else
            eq = ((x >> (23 - m)) == (y >> (23 - m)));
        return eq ? 32'd1 : 32'd0;
    endfunction

    // Apply one cycle of stimulus and record what must appear after the next edge.
    task automatic drive(input int id, input logic [31:0] x, input logic [31:0] y,
                         input logic e, input logic r);
        exp_t t;
        @(negedge clk);
        a   = x;
        b   = y;
        en  = e;
        rst = r;
        t.id    = id;
        t.exp7  = model(x, y, e, r, 7);
        t.exp23 = model(x, y, e, r, 23);
        exp_q.push_back(t);
    endtask

    // Monitor: each edge retires the oldest expectation.
    initial begin
        exp_t t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                total++;
                if (out7 !== t.exp7) begin
                    bad++;
                    $display("FAIL case%0d m7: got %h want %h (a=%h b=%h)", t.id, out7, t.exp7, a, b);
                end
                total++;
                if (out23 !== t.exp23) begin
                    bad++;
                    $display("FAIL case%0d m23: got %h want %h", t.id, out23, t.exp23);
                end
            end
        end
    end

    logic [31:0] specials [0:9];
    initial begin
        specials[0] = 32'h0000_0000; specials[1] = 32'h8000_0000;
        specials[2] = 32'h7F80_0000; specials[3] = 32'hFF80_0000;
        specials[4] = 32'h7F80_0001; specials[5] = 32'h7FC0_0000;
        specials[6] = 32'h0000_0001; specials[7] = 32'h0000_8000;
        specials[8] = 32'h8000_0001; specials[9] = 32'hFFC0_0000;
    end

    // Stimulus: reset, directed plan, then randomized mix.
    initial begin
        logic [31:0] x;
        logic [31:0] y;
        int          mode;
        int          wait_cnt;
        rst = 1'b1; en = 1'b0; a = 32'd0; b = 32'd0;
        drive(0, 32'h4020_0000, 32'h4020_0000, 1'b1, 1'b1);
        drive(1, 32'h4020_0000, 32'h4020_0000, 1'b1, 1'b0);
        drive(2, 32'h4020_0000, 32'h4020_0000, 1'b1, 1'b1);
        drive(3, 32'h4093_3333, 32'h4093_8A3F, 1'b1, 1'b0);
        drive(4, 32'h4200_0000, 32'h4200_0106, 1'b1, 1'b0);
        drive(5, 32'hC143_3333, 32'h4160_0000, 1'b1, 1'b0);
        drive(6, 32'h42E0_0000, 32'h42F0_0000, 1'b1, 1'b0);
        drive(7, 32'hC2DE_0000, 32'hC302_0000, 1'b1, 1'b0);
        drive(8, 32'h4268_0000, 32'h4268_0000, 1'b0, 1'b0);
        drive(9, 32'h4268_0000, 32'h4268_0000, 1'b1, 1'b0);
        drive(10, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
        drive(11, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0);
        drive(12, 32'h7F80_0000, 32'hFF80_0000, 1'b1, 1'b0);
        drive(13, 32'h7F80_0001, 32'h7F80_0000, 1'b1, 1'b0);
        drive(14, 32'h7F80_0001, 32'h7F80_0001, 1'b1, 1'b0);
        drive(15, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        drive(16, 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0);
        drive(17, 32'h7F80_0001, 32'h7F80_0000, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            mode = $urandom_range(0, 4);
            x = $urandom;
            case (mode)
                0: y = $urandom;
                1: y = x;
                2: y = x ^ ($urandom & 32'h0000_FFFF);
                3: y = x ^ (32'd1 << $urandom_range(0, 31));
                default: begin
                    x = specials[$urandom_range(0, 9)];
                    y = specials[$urandom_range(0, 9)];
                end
            endcase
            drive(100 + i, x, y, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
        end
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
